// File: rtl/sensor_sync_decoder.sv
// sensor_sync_decoder: pixel-domain stage after the LVDS deserializer.
// Finds embedded sync codes (all-ones, zero, zero, code word), strips them
// from the stream, and emits active pixels with SOF/EOL/frame-end markers,
// the measured line width, a line count and a lock indicator.
// Optional feature macro: SYNC_DEC_ERR_CNT_EN adds err_clr / sync_err_cnt.
// Handshake: px_din_vld qualifies px_din; when low the whole block holds and
// every output pulse (px_dout_vld, px_sof, px_eol, px_frame_end) is 0.
module sensor_sync_decoder #(
    parameter int DATA_W     = 12,
    parameter int CNT_W      = 14,
    parameter int LOCK_LINES = 4
) (
    input  logic              px_clk,
    input  logic              px_reset,
    input  logic [DATA_W-1:0] px_din,
    input  logic              px_din_vld,
`ifdef SYNC_DEC_ERR_CNT_EN
    input  logic              err_clr,
    output logic [15:0]       sync_err_cnt,
`endif
    output logic [DATA_W-1:0] px_dout,
    output logic              px_dout_vld,
    output logic              px_sof,
    output logic              px_eol,
    output logic              px_frame_end,
    output logic [CNT_W-1:0]  line_width,
    output logic [CNT_W-1:0]  line_cnt,
    output logic              sync_locked
);

    typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_P3} state_t;

    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [DATA_W-1:0] ZERO     = '0;
    localparam logic [3:0]        LOCK_MAX = 4'(LOCK_LINES);

    state_t state, state_nxt;

    // Delay line: index 0 is stage 1, index 3 is stage 4 (the output stage).
    logic [3:0][DATA_W-1:0] pipe_w;
    logic [3:0]             pipe_tag;

    logic             active;
    logic             sof_pending;
    logic [CNT_W-1:0] pix_cnt;
    logic [3:0]       lock_cnt;

    // Code word decode strobes, only ever high on an accepted word.
    logic code_hit, sync_err, eav, sav_act, sav_blank;
    logic             eav_act, pix_sat, lock_mismatch;
    logic [CNT_W-1:0] width_new;

    // Preamble FSM state register.
    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Preamble FSM next state; only accepted words advance it.
    always_comb begin
        state_nxt = state;
        if (px_din_vld) begin
            case (state)
                S_IDLE: if (px_din == ALL_ONES) state_nxt = S_P1;
                S_P1: begin
                    if (px_din == ZERO)          state_nxt = S_P2;
                    else if (px_din == ALL_ONES) state_nxt = S_P1;
                    else                         state_nxt = S_IDLE;
                end
                S_P2:    state_nxt = (px_din == ZERO) ? S_P3 : S_IDLE;
                S_P3:    state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Preamble FSM outputs: classify the code word seen in S_P3.
    always_comb begin
        code_hit  = 1'b0;
        sync_err  = 1'b0;
        eav       = 1'b0;
        sav_act   = 1'b0;
        sav_blank = 1'b0;
        if (px_din_vld && state == S_P3) begin
            code_hit = 1'b1;
            if (!px_din[DATA_W-1])     sync_err  = 1'b1;
            else if (px_din[DATA_W-3]) eav       = 1'b1;
            else if (px_din[DATA_W-2]) sav_blank = 1'b1;
            else                       sav_act   = 1'b1;
        end
    end

    // The three preamble words were tagged and counted before the code word
    // was recognised, so the true width is three less than pix_cnt.
    assign eav_act       = eav & active;
    assign pix_sat       = &pix_cnt;
    assign width_new     = pix_cnt - CNT_W'(3);
    assign lock_mismatch = eav_act &
                           (pix_sat || width_new != line_width || width_new == '0);

    // Delay line shift; a decoded code word untags itself and the preamble.
    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            pipe_w   <= '0;
            pipe_tag <= '0;
        end else if (px_din_vld) begin
            pipe_w   <= {pipe_w[2:0], px_din};
            pipe_tag <= code_hit ? 4'b0000 : {pipe_tag[2:0], active};
        end
    end

    // Line/frame timing: active flag, pixel and line counters, SOF arming.
    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            active      <= 1'b0;
            sof_pending <= 1'b0;
            pix_cnt     <= '0;
            line_width  <= '0;
            line_cnt    <= '0;
        end else if (px_din_vld) begin
            if (sav_act)               active <= 1'b1;
            else if (eav || sav_blank) active <= 1'b0;

            if (eav || sav_act || sav_blank)       pix_cnt <= '0;
            else if (active && !code_hit && !pix_sat) pix_cnt <= pix_cnt + 1'b1;

            if (eav_act) line_width <= width_new;

            if (eav_act)                          line_cnt <= line_cnt + 1'b1;
            else if (sav_blank && line_cnt != '0) line_cnt <= '0;

            if (sav_blank)        sof_pending <= 1'b1;
            else if (px_dout_vld) sof_pending <= 1'b0;
        end
    end

    // Lock tracking: consecutive equal nonzero widths, errors restart it.
    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            lock_cnt <= '0;
        end else if (px_din_vld) begin
            if (sync_err)                 lock_cnt <= '0;
            else if (lock_mismatch)       lock_cnt <= 4'd1;
            else if (eav_act && lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
        end
    end

`ifdef SYNC_DEC_ERR_CNT_EN
    // Saturating error counter; err_clr wins over an increment.
    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset)
            sync_err_cnt <= '0;
        else if (err_clr)
            sync_err_cnt <= '0;
        else if (px_din_vld && (sync_err || lock_mismatch) && sync_err_cnt != 16'hFFFF)
            sync_err_cnt <= sync_err_cnt + 1'b1;
    end
`endif

    // At the EAV code cycle the last true pixel sits in stage 4 (preamble
    // fills stages 1-3), so EOL is flagged on stage 4 in that same cycle.
    assign sync_locked  = (lock_cnt == LOCK_MAX);
    assign px_dout      = pipe_w[3];
    assign px_dout_vld  = px_din_vld & pipe_tag[3] & sync_locked;
    assign px_eol       = px_dout_vld & eav;
    assign px_sof       = px_dout_vld & sof_pending;
    assign px_frame_end = sav_blank & (line_cnt != '0);

endmodule

// File: tb/tb_sensor_sync_decoder.sv
// Testbench for sensor_sync_decoder: directed lines and frames, scoreboard
// of expected output pixels checked by an independent monitor.
module tb_sensor_sync_decoder;

    localparam int DATA_W     = 12;
    localparam int CNT_W      = 14;
    localparam int LOCK_LINES = 4;

    localparam logic [DATA_W-1:0] SAV_ACT   = 12'h800;
    localparam logic [DATA_W-1:0] EAV_ACT   = 12'hA00;
    localparam logic [DATA_W-1:0] SAV_BLANK = 12'hC00;
    localparam logic [DATA_W-1:0] BAD_CODE  = 12'h400;
    localparam logic [DATA_W-1:0] FILLER    = 12'h050;

    logic              px_clk = 1'b0;
    logic              px_reset;
    logic [DATA_W-1:0] px_din;
    logic              px_din_vld;
    logic [DATA_W-1:0] px_dout;
    logic              px_dout_vld, px_sof, px_eol, px_frame_end, sync_locked;
    logic [CNT_W-1:0]  line_width, line_cnt;
`ifdef SYNC_DEC_ERR_CNT_EN
    logic              err_clr;
    logic [15:0]       sync_err_cnt;
`endif

    // Expected output pixel: {word, eol, sof}
    logic [DATA_W+1:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    bit stall_en = 1'b0;

    // Bench model of line/lock timing
    int m_lock = 0;
    int m_w = 0;
    int m_lines = 0;
    bit m_sof = 1'b0;

    sensor_sync_decoder #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .LOCK_LINES(LOCK_LINES)
    ) dut (
        .px_clk(px_clk),
        .px_reset(px_reset),
        .px_din(px_din),
        .px_din_vld(px_din_vld),
`ifdef SYNC_DEC_ERR_CNT_EN
        .err_clr(err_clr),
        .sync_err_cnt(sync_err_cnt),
`endif
        .px_dout(px_dout),
        .px_dout_vld(px_dout_vld),
        .px_sof(px_sof),
        .px_eol(px_eol),
        .px_frame_end(px_frame_end),
        .line_width(line_width),
        .line_cnt(line_cnt),
        .sync_locked(sync_locked)
    );

    // Clock
    always #5 px_clk = ~px_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented pixel against the scoreboard
    always @(negedge px_clk) begin
        if (px_frame_end) fe_seen++;
        if (px_dout_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got %h eol=%b sof=%b expected none",
                         px_dout, px_eol, px_sof);
            end else begin
                logic [DATA_W+1:0] e;
                e = exp_q.pop_front();
                if ({px_dout, px_eol, px_sof} !== e) begin
                    n_err++;
                    $display("FAIL pixel: got %h eol=%b sof=%b expected %h eol=%b sof=%b",
                             px_dout, px_eol, px_sof, e[DATA_W+1:2], e[1], e[0]);
                end
            end
        end
    end

    // Driver: one accepted word, optionally preceded by a stall cycle
    task automatic send_word(input logic [DATA_W-1:0] w);
        if (stall_en) begin
            @(posedge px_clk); #1;
            px_din_vld = 1'b0;
            px_din     = DATA_W'($urandom);
        end
        @(posedge px_clk); #1;
        px_din_vld = 1'b1;
        px_din     = w;
    endtask

    task automatic send_code(input logic [DATA_W-1:0] c);
        send_word(12'hFFF);
        send_word(12'h000);
        send_word(12'h000);
        send_word(c);
    endtask

    task automatic flush(input int k);
        for (int i = 0; i < k; i++) send_word(FILLER);
        @(negedge px_clk);
    endtask

    // One active line of n pixels base, base+1, ...; expected outputs pushed
    // only when the model says the block is locked while the line drains.
    task automatic send_line(input int n, input logic [DATA_W-1:0] base);
        bit locked;
        bit ok;
        locked = (m_lock == LOCK_LINES);
        for (int i = 0; i < n; i++) begin
            if (locked) begin
                exp_q.push_back({base + DATA_W'(i), (i == n - 1), (m_sof && i == 0)});
            end
        end
        if (locked && n > 0) m_sof = 1'b0;
        send_code(SAV_ACT);
        for (int i = 0; i < n; i++) send_word(base + DATA_W'(i));
        send_code(EAV_ACT);
        ok = (n == m_w) && (n != 0);
        m_lock = ok ? ((m_lock < LOCK_LINES) ? m_lock + 1 : m_lock) : 1;
        m_w = n;
        m_lines++;
    endtask

    task automatic send_blank_sav();
        send_code(SAV_BLANK);
        m_sof = 1'b1;
        if (m_lines > 0) fe_exp++;
        m_lines = 0;
    endtask

    initial begin
        px_reset   = 1'b1;
        px_din_vld = 1'b0;
        px_din     = '0;
`ifdef SYNC_DEC_ERR_CNT_EN
        err_clr    = 1'b0;
`endif
        repeat (3) @(posedge px_clk);
        @(negedge px_clk);
        check("reset_locked", sync_locked, 0);
        check("reset_width", line_width, 0);
        check("reset_line_cnt", line_cnt, 0);
        check("reset_dout", px_dout, 0);
        @(posedge px_clk); #1;
        px_reset = 1'b0;

        // Acquire lock on 8-pixel lines; no pixels leave during acquisition
        for (int l = 0; l < 4; l++) send_line(8, 12'h100);
        flush(2);
        check("lock_after_4", sync_locked, 1);
        check("width_8", line_width, 8);
        check("line_cnt_4", line_cnt, 4);

        // Two locked lines are emitted
        send_line(8, 12'h100);
        send_line(8, 12'h100);
        flush(2);
        check("line_cnt_6", line_cnt, 6);

        // Frame boundary
        send_blank_sav();
        flush(2);
        check("frame_end_count", fe_seen, fe_exp);
        check("line_cnt_cleared", line_cnt, 0);
        send_line(8, 12'h300);
        flush(2);
        check("line_cnt_new_frame", line_cnt, 1);

        // Width change drops lock, then three more lines re-lock
        send_line(7, 12'h400);
        flush(2);
        check("unlock_on_width_change", sync_locked, 0);
        check("width_7", line_width, 7);
        for (int l = 0; l < 3; l++) send_line(7, 12'h400);
        flush(2);
        check("relock_width_7", sync_locked, 1);

        // Stalled line behaves like an unstalled one
        stall_en = 1'b1;
        send_line(7, 12'h500);
        flush(2);
        stall_en = 1'b0;
        check("stall_width", line_width, 7);
        check("stall_locked", sync_locked, 1);

        // Bad code word
`ifdef SYNC_DEC_ERR_CNT_EN
        @(posedge px_clk); #1; err_clr = 1'b1;
        @(posedge px_clk); #1; err_clr = 1'b0;
`endif
        send_code(BAD_CODE);
        m_lock = 0;
        flush(2);
        check("bad_code_unlock", sync_locked, 0);
`ifdef SYNC_DEC_ERR_CNT_EN
        check("err_cnt_one", sync_err_cnt, 1);
        @(posedge px_clk); #1; err_clr = 1'b1;
        @(posedge px_clk); #1; err_clr = 1'b0;
        @(negedge px_clk);
        check("err_cnt_cleared", sync_err_cnt, 0);
`endif

        // Re-lock, then reset while pixel 5 of a locked line is driven
        for (int l = 0; l < 4; l++) send_line(7, 12'h600);
        flush(2);
        check("relock_before_reset", sync_locked, 1);
        exp_q.push_back({12'h200, 1'b0, 1'b0});
        send_code(SAV_ACT);
        for (int i = 0; i < 5; i++) send_word(12'h200 + DATA_W'(i));
        @(posedge px_clk); #1;
        px_din     = 12'h205;
        px_din_vld = 1'b1;
        px_reset   = 1'b1;
        @(negedge px_clk);
        check("rst_dout_vld", px_dout_vld, 0);
        check("rst_dout", px_dout, 0);
        check("rst_eol_sof_fe", {px_eol, px_sof, px_frame_end}, 0);
        check("rst_locked", sync_locked, 0);
        check("rst_width", line_width, 0);
        check("rst_line_cnt", line_cnt, 0);
        @(posedge px_clk); #1;
        px_reset   = 1'b0;
        px_din_vld = 1'b0;
        m_lock = 0; m_w = 0; m_lines = 0; m_sof = 1'b0;

        // Fresh acquisition after reset
        for (int l = 0; l < 3; l++) send_line(8, 12'h100);
        flush(2);
        check("not_locked_after_3", sync_locked, 0);
        send_line(8, 12'h100);
        flush(2);
        check("locked_after_4_fresh", sync_locked, 1);
        send_line(8, 12'h700);
        flush(4);

        check("queue_drained", exp_q.size(), 0);
        check("frame_end_total", fe_seen, fe_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
